// File: rtl/io_debounce.sv
// io_debounce
// Synchronises and debounces a bank of mechanical switch inputs. It presents
// clean levels, one-cycle rise/fall pulses, and a sticky change mask with a
// valid/ack handshake, so a slow consumer cannot miss any switch event.
//
// Ports:
//   clk        system clock; all logic runs on its rising edge
//   rst        synchronous, active-high reset
//   sw         raw asynchronous switch inputs [WIDTH]
//   chg_ack    consumer acknowledge; clears the change mask
//   sw_db      debounced switch levels [WIDTH]
//   sw_rise    one-cycle pulse per bit on an accepted 0->1 transition [WIDTH]
//   sw_fall    one-cycle pulse per bit on an accepted 1->0 transition [WIDTH]
//   chg_mask   sticky OR of accepted edges since the last ack [WIDTH]
//   chg_valid  high while chg_mask is non-zero
module io_debounce #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 100_000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             chg_ack,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] chg_mask,
  output logic             chg_valid
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [TW-1:0]    tcnt_reg;
  logic             tick;

  logic [WIDTH-1:0] sw_db_reg;
  logic [WIDTH-1:0] sw_rise_reg;
  logic [WIDTH-1:0] sw_fall_reg;
  logic [WIDTH-1:0] chg_mask_reg;
  logic [WIDTH-1:0] sw_rise_next;
  logic [WIDTH-1:0] sw_fall_next;
  logic [WIDTH-1:0] chg_mask_next;

  // Two-flop synchroniser. Only s2 feeds the qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= sw;
      s2_reg <= s1_reg;
    end
  end

  // Free-running sample-tick divider shared by every bit.
  assign tick = (tcnt_reg == TW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_reg <= '0;
    end else if (tick) begin
      tcnt_reg <= '0;
    end else begin
      tcnt_reg <= tcnt_reg + TW'(1);
    end
  end

  // Per-bit qualifier. It counts sample ticks while the synchronised input
  // differs from the debounced level. Any return to the old level restarts
  // the count, so short glitches never get through.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_reg;
      logic          db_bit_reg;
      logic          differs;
      logic          accept;

      assign differs = (s2_reg[gi] != db_bit_reg);
      assign accept  = differs && tick && (cnt_reg == CW'(STABLE_TICKS - 1));

      assign sw_rise_next[gi] = accept &  s2_reg[gi];
      assign sw_fall_next[gi] = accept & ~s2_reg[gi];
      assign sw_db_reg[gi]    = db_bit_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg    <= '0;
          db_bit_reg <= 1'b0;
        end else if (!differs) begin
          cnt_reg <= '0;
        end else if (accept) begin
          db_bit_reg <= s2_reg[gi];
          cnt_reg    <= '0;
        end else if (tick) begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end
    end
  endgenerate

  // The edges registered on this clock are ORed in after the ack clear. An
  // edge that coincides with chg_ack therefore survives into the new mask.
  assign chg_mask_next = (chg_ack ? '0 : chg_mask_reg) | sw_rise_next | sw_fall_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_rise_reg  <= '0;
      sw_fall_reg  <= '0;
      chg_mask_reg <= '0;
    end else begin
      sw_rise_reg  <= sw_rise_next;
      sw_fall_reg  <= sw_fall_next;
      chg_mask_reg <= chg_mask_next;
    end
  end

  assign sw_db     = sw_db_reg;
  assign sw_rise   = sw_rise_reg;
  assign sw_fall   = sw_fall_reg;
  assign chg_mask  = chg_mask_reg;
  assign chg_valid = |chg_mask_reg;

endmodule

// File: tb/tb_io_debounce.sv
// Testbench for io_debounce (WIDTH=16, TICK_DIV=4, STABLE_TICKS=3).
// A behavioural model derives the expected outputs from tick-count arithmetic.
// It counts how many ticks fall inside each bit's continuous "differs"
// interval. The DUT is compared against the model on every cycle. Directed
// scenarios add hand-computed literal expectations.
module tb_io_debounce;
  localparam int W  = 16;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw = '1;
  logic         chg_ack = 1'b0;
  logic [W-1:0] sw_db, sw_rise, sw_fall, chg_mask;
  logic         chg_valid;

  int checks = 0;
  int errors = 0;

  io_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .sw(sw), .chg_ack(chg_ack),
    .sw_db(sw_db), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .chg_mask(chg_mask), .chg_valid(chg_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_mask;
  int           m_cyc;          // index of the cycle the next edge evaluates
  int           diff_start[W];  // first cycle of the current "differs" run, -1 if none
  bit           model_ok = 0;

  // Number of tick cycles (c % TD == TD-1) in the inclusive range [a, b].
  function automatic int nticks(input int a, input int b);
    return (b + 1) / TD - a / TD;
  endfunction

  always @(posedge clk) begin
    logic [W-1:0] rn, fn, dn;
    model_ok = 1;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_mask = '0;
      m_cyc = 0;
      for (int i = 0; i < W; i++) diff_start[i] = -1;
    end else begin
      rn = '0; fn = '0; dn = m_db;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_db[i]) begin
          if (diff_start[i] < 0) diff_start[i] = m_cyc;
          if ((m_cyc % TD == TD - 1) && nticks(diff_start[i], m_cyc) == ST) begin
            dn[i] = m_s2[i];
            if (m_s2[i]) rn[i] = 1'b1; else fn[i] = 1'b1;
            diff_start[i] = -1;
          end
        end else begin
          diff_start[i] = -1;
        end
      end
      m_mask = (chg_ack ? '0 : m_mask) | rn | fn;
      m_rise = rn; m_fall = fn; m_db = dn;
      m_s2 = m_s1; m_s1 = sw;
      m_cyc++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("sw_db",     sw_db,     m_db);
      chk("sw_rise",   sw_rise,   m_rise);
      chk("sw_fall",   sw_fall,   m_fall);
      chk("chg_mask",  chg_mask,  m_mask);
      chk("chg_valid", chg_valid, |m_mask);
      chk("rise_and_fall", sw_rise & sw_fall, '0);
    end
  end

  // Pulse counters for directed checks.
  int rise_cnt[W];
  int fall_cnt[W];
  always @(negedge clk) begin
    for (int i = 0; i < W; i++) begin
      if (sw_rise[i]) rise_cnt[i]++;
      if (sw_fall[i]) fall_cnt[i]++;
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a pulse on one bit; lat counts edges since the call.
  task automatic wait_pulse(input int b, input bit rise, input int maxc, output int lat);
    lat = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      if (rise ? sw_rise[b] : sw_fall[b]) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) $display("FAIL wait_pulse bit %0d rise=%0d: got no pulse expected one", b, rise);
  endtask

  task automatic ack();
    chg_ack = 1'b1;
    @(negedge clk);
    chg_ack = 1'b0;
  endtask

  task automatic chk_lat(input string name, input int lat);
    chk(name, (lat >= 11 && lat <= 14), 1);
  endtask

  initial begin
    int lat, base, a, t1, acc;
    for (int i = 0; i < W; i++) diff_start[i] = -1;
    clear_counts();

    // Reset with all switches high.
    repeat (3) begin
      @(negedge clk);
      chk("rst_sw_db", sw_db, 16'h0000);
      chk("rst_rise", sw_rise, 16'h0000);
      chk("rst_valid", chg_valid, 0);
    end
    rst = 1'b0;
    wait_pulse(0, 1, 20, lat);
    chk("t1_lat", lat, 12);
    chk("t1_rise", sw_rise, 16'hFFFF);
    chk("t1_db", sw_db, 16'hFFFF);
    chk("t1_mask", chg_mask, 16'hFFFF);
    chk("t1_valid", chg_valid, 1);
    ack();
    chk("t1_rise_gone", sw_rise, 16'h0000);
    chk("t1_mask_clr", chg_mask, 16'h0000);
    sw = '0;
    wait_pulse(0, 0, 20, lat);
    chk_lat("t1_fall_lat", lat);
    chk("t1_fall", sw_fall, 16'hFFFF);
    ack();
    chk("t1_mask_clr2", chg_mask, 16'h0000);

    // Glitch rejection.
    clear_counts();
    sw = 16'h0008;
    cycles(6);
    sw = '0;
    cycles(20);
    chk("t2_db", sw_db, 16'h0000);
    chk("t2_valid", chg_valid, 0);
    chk("t2_pulses", rise_cnt[3] + fall_cnt[3], 0);

    // Clean press and release.
    clear_counts();
    sw = 16'h0001;
    wait_pulse(0, 1, 20, lat);
    chk_lat("t3_rise_lat", lat);
    if (lat > 0) cycles(20 - lat);
    sw = 16'h0000;
    wait_pulse(0, 0, 20, lat);
    chk_lat("t3_fall_lat", lat);
    cycles(20);
    chk("t3_rise_cnt", rise_cnt[0], 1);
    chk("t3_fall_cnt", fall_cnt[0], 1);
    chk("t3_mask", chg_mask, 16'h0001);

    // Ack arriving in the same cycle as an accept on bit 5.
    base = m_cyc;
    sw = 16'h0020;
    a  = base + 2;
    t1 = a + ((TD - 1) - (a % TD));
    acc = t1 + (ST - 1) * TD;
    cycles(acc - base);
    chk("t4_mask_pre", chg_mask, 16'h0001);
    chk("t4_rise_pre", sw_rise, 16'h0000);
    ack();
    chk("t4_mask", chg_mask, 16'h0020);
    chk("t4_valid", chg_valid, 1);
    chk("t4_rise", sw_rise, 16'h0020);
    ack();
    chk("t4_mask_clr", chg_mask, 16'h0000);

    // Eight bits accepted together.
    sw = 16'hFF20;
    wait_pulse(8, 1, 20, lat);
    chk_lat("t5_lat", lat);
    chk("t5_rise", sw_rise, 16'hFF00);
    chk("t5_mask", chg_mask, 16'hFF00);
    ack();
    chk("t5_mask_clr", chg_mask, 16'h0000);
    chk("t5_valid", chg_valid, 0);

    // Reset in the middle of a qualification.
    clear_counts();
    sw = 16'hFF24;
    cycles(8);
    chk("t6_no_rise_pre", rise_cnt[2], 0);
    rst = 1'b1;
    cycles(2);
    chk("t6_db_rst", sw_db, 16'h0000);
    chk("t6_mask_rst", chg_mask, 16'h0000);
    rst = 1'b0;
    chk("t6_no_rise_rst", rise_cnt[2], 0);
    wait_pulse(2, 1, 20, lat);
    chk("t6_lat", lat, 12);
    chk("t6_rise", sw_rise, 16'hFF24);
    chk("t6_db", sw_db, 16'hFF24);
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/io_debounce.md
# io_debounce

Input-side counterpart to the LED/PWM output path: samples the 16 board switches, synchronises and debounces them, and presents clean levels plus one-cycle rise/fall pulses to downstream logic. A sticky change mask with a valid/ack handshake lets a slower consumer (control FSM, register file) collect switch events without missing any. Sits directly behind the top-level `sw` pins, in the `clk` domain.

## Interface
- `WIDTH`, 16, number of switch inputs.
- `TICK_DIV`, 100_000, `clk` cycles per sample tick (1 ms at 100 MHz); must be ≥ 2.
- `STABLE_TICKS`, 10, consecutive ticks an input must differ from `sw_db` before it is accepted; must be ≥ 1.

- `clk`  in  1  system clock, 100 MHz; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw`  in  WIDTH  raw asynchronous switch inputs.
- `chg_ack`  in  1  consumer acknowledge; clears the change mask.
- `sw_db`  out  WIDTH  debounced switch levels.
- `sw_rise`  out  WIDTH  one-cycle pulse per bit on accepted 0→1.
- `sw_fall`  out  WIDTH  one-cycle pulse per bit on accepted 1→0.
- `chg_mask`  out  WIDTH  sticky OR of accepted edges since last ack.
- `chg_valid`  out  1  high while `chg_mask` is non-zero.

## Operation
- Synchroniser: two flops per bit, `sw` → `s1` → `s2`. Only `s2` is used downstream.
- Tick generator: counter `tcnt`, width `$clog2(TICK_DIV)`, counts 0..TICK_DIV-1 and wraps to 0. `tick` is high in the cycle where `tcnt == TICK_DIV-1`. The counter is free-running and shared by all bits.
- Per-bit qualifier: counter `cnt[i]`, width `$clog2(STABLE_TICKS+1)`.
  - If `s2[i] == sw_db[i]`: `cnt[i] <= 0`. A glitch shorter than qualification is discarded.
  - Else if `tick` and `cnt[i] == STABLE_TICKS-1`: `sw_db[i] <= s2[i]`, `cnt[i] <= 0`. Pulse `sw_rise[i]` if `s2[i]` is 1, otherwise pulse `sw_fall[i]`.
  - Else if `tick`: `cnt[i] <= cnt[i] + 1`.
  - Otherwise: hold.
- `sw_rise` and `sw_fall` are registered. Each pulse is high for exactly one cycle, coincident with the first cycle of the new `sw_db` value. A bit never has rise and fall high together.
- Change mask: `chg_mask <= (chg_ack ? 0 : chg_mask) | sw_rise_next | sw_fall_next`.
  - `*_next` are the values being registered into `sw_rise`/`sw_fall` on that same edge.
  - An edge arriving in the same cycle as `chg_ack` is therefore kept, not lost.
- `chg_valid` is `|chg_mask`, driven from the registered mask with no extra delay.
- Handshake: the consumer reads `chg_mask` while `chg_valid` is high and pulses `chg_ack` for one cycle. `chg_ack` while `chg_valid` is low is harmless.

## Timing
- Reset values: `s1`, `s2`, `tcnt`, `cnt`, `sw_db`, `sw_rise`, `sw_fall`, `chg_mask` are all 0, so `chg_valid` is 0.
- After reset release, `tick` first fires when `tcnt` reaches TICK_DIV-1, i.e. TICK_DIV cycles after the first non-reset edge.
- Latency:
  - `sw` → `s2`: 2 cycles.
  - `s2` → `sw_db`: between (STABLE_TICKS-1)·TICK_DIV+1 and STABLE_TICKS·TICK_DIV cycles, depending on tick phase.
- Minimum accepted input pulse width equals that latency. Shorter pulses produce no output change.
- An input held high through reset is re-qualified from `sw_db = 0` and produces a normal `sw_rise` after the full latency.
- Reset mid-qualification discards the partial count.
- Reset asserted in the same cycle as an accept wins: outputs go to 0 and no pulse is emitted.
- `tcnt` wrap and `cnt` saturation: `cnt` never exceeds STABLE_TICKS-1, because acceptance resets it.
- Multiple bits may accept on the same tick. Their pulses and mask bits are set in the same cycle.

## Test plan
Bench parameters: WIDTH=16, TICK_DIV=4, STABLE_TICKS=3.
- Reset behaviour: hold `rst` for 3 cycles with `sw=16'hFFFF` → all outputs 0 during reset. After release, `sw_db` becomes 16'hFFFF within 2+12 cycles. `sw_rise=16'hFFFF` for exactly one cycle, then `chg_mask=16'hFFFF` and `chg_valid=1`.
- Glitch rejection: with `sw_db=0`, drive `sw[3]=1` for 6 cycles, then 0 → `sw_db` stays 0, no rise/fall, `chg_valid` stays 0.
- Clean press/release: `sw[0]` 0→1 held 20 cycles, then 1→0 held 20 cycles → one `sw_rise[0]` pulse 11–14 cycles after the rising input edge, and one `sw_fall[0]` pulse within 11–14 cycles of the falling edge.
- Ack/edge collision: set `chg_mask=16'h0001`. Arrange `sw[5]` to accept in the same cycle `chg_ack=1` → next cycle `chg_mask=16'h0020` and `chg_valid=1`.
- Simultaneous bits: toggle `sw[15:8]` 0→1 together and hold → `sw_rise=16'hFF00` in a single cycle and `chg_mask=16'hFF00`. `chg_ack` then clears the mask to 0.
- Reset mid-qualification: raise `sw[2]` and assert `rst` after 8 cycles → no pulse. After release, a full 11–14-cycle qualification restarts from 0.
